// File: rtl/rv32i_writeback_if.sv
// rv32i_writeback_if: ALU/load result inputs and register-file write outputs of the writeback stage.
// RV32I_WB_FWD_EN adds the combinational forwarding signals.
interface rv32i_writeback_if #(
   parameter int XLEN = 32
);
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd_addr;
   logic [XLEN-1:0] alu_rd_data;
   logic            ld_valid;
   logic [4:0]      ld_rd_addr;
   logic [XLEN-1:0] ld_word;
   logic [2:0]      ld_funct3;
   logic [1:0]      ld_off;
   logic            rd_we;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            ld_misalign;
   logic [31:0]     wb_count;
`ifdef RV32I_WB_FWD_EN
   logic            fwd_valid;
   logic [4:0]      fwd_addr;
   logic [XLEN-1:0] fwd_data;
   modport master (
      output alu_valid, alu_rd_addr, alu_rd_data, ld_valid, ld_rd_addr, ld_word, ld_funct3, ld_off,
      input  alu_ready, rd_we, rd_addr, rd_data, ld_misalign, wb_count, fwd_valid, fwd_addr, fwd_data
   );
   modport slave (
      input  alu_valid, alu_rd_addr, alu_rd_data, ld_valid, ld_rd_addr, ld_word, ld_funct3, ld_off,
      output alu_ready, rd_we, rd_addr, rd_data, ld_misalign, wb_count, fwd_valid, fwd_addr, fwd_data
   );
`else
   modport master (
      output alu_valid, alu_rd_addr, alu_rd_data, ld_valid, ld_rd_addr, ld_word, ld_funct3, ld_off,
      input  alu_ready, rd_we, rd_addr, rd_data, ld_misalign, wb_count
   );
   modport slave (
      input  alu_valid, alu_rd_addr, alu_rd_data, ld_valid, ld_rd_addr, ld_word, ld_funct3, ld_off,
      output alu_ready, rd_we, rd_addr, rd_data, ld_misalign, wb_count
   );
`endif
endinterface

// File: rtl/rv32i_writeback.sv
// rv32i_writeback: load-priority writeback stage with load alignment/extension and a commit counter.
// Define RV32I_WB_FWD_EN to drive the combinational forwarding outputs of the interface.
module rv32i_writeback #(
   parameter int XLEN = 32
) (
   input logic              clk,
   input logic              rst_n,
   rv32i_writeback_if.slave wb
);
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic            ld_ok;
   logic [XLEN-1:0] ld_data;
   logic            acc_d;
   logic            we_d;
   logic [4:0]      addr_d;
   logic [XLEN-1:0] data_d;
   logic            rd_we_q;
   logic [4:0]      rd_addr_q;
   logic [XLEN-1:0] rd_data_q;
   logic            misalign_q;
   logic [31:0]     wb_count_q;
   always_comb begin
      ld_byte = wb.ld_word[8*wb.ld_off +: 8];
      ld_half = wb.ld_off[1] ? wb.ld_word[31:16] : wb.ld_word[15:0];
      ld_ok   = (wb.ld_funct3 inside {3'b000, 3'b100})
             || ((wb.ld_funct3 inside {3'b001, 3'b101}) && !wb.ld_off[0])
             || (wb.ld_funct3 == 3'b010 && wb.ld_off == 2'd0);
      // funct3[2] marks the unsigned variants, so it gates the sign bit
      ld_data = wb.ld_funct3[1] ? wb.ld_word
              : wb.ld_funct3[0] ? {{(XLEN-16){!wb.ld_funct3[2] & ld_half[15]}}, ld_half}
              : {{(XLEN-8){!wb.ld_funct3[2] & ld_byte[7]}}, ld_byte};
      acc_d   = wb.ld_valid ? ld_ok : wb.alu_valid;
      addr_d  = wb.ld_valid ? wb.ld_rd_addr : wb.alu_rd_addr;
      data_d  = wb.ld_valid ? ld_data : wb.alu_rd_data;
      we_d    = acc_d && addr_d != 5'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_we_q    <= 1'b0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
         misalign_q <= 1'b0;
         wb_count_q <= '0;
      end else begin
         rd_we_q    <= we_d;
         misalign_q <= wb.ld_valid && !ld_ok;
         wb_count_q <= wb_count_q + {31'd0, we_d};
         if (acc_d) begin
            rd_addr_q <= addr_d;
            rd_data_q <= data_d;
         end
      end
   end
   assign wb.alu_ready   = !wb.ld_valid;
   assign wb.rd_we       = rd_we_q;
   assign wb.rd_addr     = rd_addr_q;
   assign wb.rd_data     = rd_data_q;
   assign wb.ld_misalign = misalign_q;
   assign wb.wb_count    = wb_count_q;
`ifdef RV32I_WB_FWD_EN
   assign wb.fwd_valid = we_d && rst_n;
   assign wb.fwd_addr  = addr_d;
   assign wb.fwd_data  = data_d;
`endif
endmodule

// File: doc/rv32i_writeback.md
RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

Interface
REQ-001 Parameter XLEN, default 32, data width of all data ports; only 32 is supported.
REQ-002 Port clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port alu_valid  in  1  ALU result offered.
REQ-005 Port alu_ready  out  1  ALU result accepted this cycle.
REQ-006 Port alu_rd_addr  in  5  ALU destination register.
REQ-007 Port alu_rd_data  in  32  ALU result.
REQ-008 Port ld_valid  in  1  load result offered; always accepted.
REQ-009 Port ld_rd_addr  in  5  load destination register.
REQ-010 Port ld_word  in  32  raw aligned memory word.
REQ-011 Port ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 Port ld_off  in  2  byte offset of the load address.
REQ-013 Port rd_we  out  1  register-file write enable.
REQ-014 Port rd_addr  out  5  register-file write address.
REQ-015 Port rd_data  out  32  register-file write data.
REQ-016 Port ld_misalign  out  1  one-cycle pulse for a rejected misaligned or illegal load.
REQ-017 Port wb_count  out  32  count of committed register writes.

Function
REQ-018 Load has priority: alu_ready = !ld_valid, combinational.
REQ-019 Accepted result: load when ld_valid, else ALU when alu_valid; otherwise none.
REQ-020 rd_we, rd_addr, and rd_data are registered, so an accepted result appears exactly 1 cycle after acceptance.
REQ-021 rd_we is 0 in any cycle following no acceptance; rd_addr and rd_data hold their previous values.
REQ-022 Destination x0: rd_we is 0, rd_addr and rd_data update normally, and wb_count does not increment.
REQ-023 LB/LBU select byte ld_word[8*ld_off+7 : 8*ld_off], sign-extended for LB and zero-extended for LBU.
REQ-024 LH/LHU select the halfword at ld_off (0 or 2), sign-extended for LH and zero-extended for LHU.
REQ-025 LW passes ld_word unchanged.
REQ-026 Misalignment (LH/LHU with ld_off odd, LW with ld_off != 0) or any other ld_funct3 value: no write, and ld_misalign = 1 in the next cycle.
REQ-027 A rejected load still blocks the ALU in its cycle, per REQ-018.
REQ-028 wb_count increments by 1 the cycle rd_we = 1, and wraps from 0xFFFFFFFF to 0.
REQ-029 Simultaneous alu_valid and ld_valid: the load writes, the ALU result stalls with alu_ready = 0 and is retried by the producer.

Reset
REQ-030 While rst_n = 0: rd_we = 0, rd_addr = 0, rd_data = 0, ld_misalign = 0, wb_count = 0, and fwd_valid = 0 when present.
REQ-031 Assertion mid-operation discards any registered, not-yet-written result.
REQ-032 Writes resume on the first accepted result after rst_n rises.

Configuration
REQ-033 Macro RV32I_WB_FWD_EN defined: add outputs fwd_valid (1), fwd_addr (5), and fwd_data (32), driven combinationally with the load-aligned or ALU value being accepted this cycle.
REQ-034 fwd_valid = 0 for x0 and for rejected loads.
REQ-035 Macro not defined: forwarding ports are absent, and all other behaviour is identical.

Verification
REQ-036 ALU only: alu_valid = 1, alu_rd_addr = 5, alu_rd_data = 0x12345678 -> next cycle rd_we = 1, rd_addr = 5, rd_data = 0x12345678, and wb_count 0 -> 1.
REQ-037 Load extension: ld_word = 0x80FF7F01, LB off 2 -> rd_data = 0xFFFFFFFF; LBU off 3 -> 0x00000080; LH off 2 -> 0xFFFF80FF; LHU off 0 -> 0x00007F01.
REQ-038 Collision: ALU (x3) and load (x4) in the same cycle -> alu_ready = 0, x4 written first, and x3 written one cycle after the ALU retry.
REQ-039 Misalign: LW off 1, ld_rd_addr = 7 -> rd_we = 0, ld_misalign pulses for 1 cycle, and wb_count is unchanged.
REQ-040 x0 and wrap: write to x0 -> rd_we = 0; after forcing wb_count to 0xFFFFFFFF, one write gives wb_count = 0.
REQ-041 Reset mid-stream: drop rst_n while a result is pending -> rd_we = 0 immediately and wb_count = 0; with RV32I_WB_FWD_EN, fwd_data equals the next cycle's rd_data.
